rom_loader: RTL and testbench

- Writer side of the instruction-memory interface: takes a byte stream (e.g. from a UART receiver or a debug host), assembles big-endian 32-bit words and writes them into instruction memory at byte addresses BASE_ADDR, BASE_ADDR+4, and so on.
- The memory is later read by the CPU fetch path through its rd/addr/dataOut port.
- Sits between the host byte source and the memory's write port; drives busy/done/error to the top level.

---
 rtl/rom_loader.sv | 157 +++++++++++++++
 tb/tb_rom_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Byte-stream to instruction-memory writer: packs big-endian bytes into 32-bit
// words and writes them to consecutive word addresses starting at BASE_ADDR.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 128,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] wordCount,
    input  logic [7:0]           byteIn,
    input  logic                 byteValid,
    output logic                 byteReady,
    output logic                 memWr,
    output logic [31:0]          memAddr,
    output logic [31:0]          memData,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One extra bit so a DEPTH_WORDS at the edge of the counter range still compares correctly.
    localparam logic [CNT_WIDTH:0] DEPTH_LIM = (CNT_WIDTH+1)'(DEPTH_WORDS);

    state_t               state_reg, state_next;
    logic [31:0]          addr_reg;
    logic [31:0]          data_reg;
    logic [31:0]          asm_reg, asm_next;
    logic [1:0]           idx_reg;
    logic [CNT_WIDTH-1:0] remaining_reg;
    logic                 error_reg;

    logic                 start_idle;
    logic                 count_zero;
    logic                 count_over;
    logic                 start_accept;
    logic                 byte_accept;
    logic                 last_byte;
    logic [3:0]           lane_load;

    assign start_idle   = (state_reg == ST_IDLE) && start;
    assign count_zero   = (wordCount == '0);
    assign count_over   = ({1'b0, wordCount} > DEPTH_LIM);
    assign start_accept = start_idle && !count_zero && !count_over;
    assign byte_accept  = byteValid && byteReady;
    assign last_byte    = byte_accept && (idx_reg == 2'd3);

    // Byte k of a word lands in bits [31-8k : 24-8k].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_load[gi] = byte_accept && (idx_reg == 2'(gi));
            assign asm_next[31-8*gi -: 8] = lane_load[gi] ? byteIn : asm_reg[31-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (count_zero) begin
                        state_next = ST_DONE;
                    end else if (!count_over) begin
                        state_next = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (last_byte) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (remaining_reg == CNT_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_COLLECT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byteReady = 1'b0;
        memWr     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                byteReady = 1'b1;
                busy      = 1'b1;
            end
            ST_WRITE: begin
                memWr = 1'b1;
                busy  = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            addr_reg      <= BASE_ADDR;
            data_reg      <= '0;
            asm_reg       <= '0;
            idx_reg       <= '0;
            remaining_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            error_reg <= start_idle && count_over;
            asm_reg   <= asm_next;
            if (start_accept) begin
                remaining_reg <= wordCount;
                addr_reg      <= BASE_ADDR;
                idx_reg       <= '0;
            end
            if (byte_accept) begin
                idx_reg <= idx_reg + 2'd1;
            end
            if (last_byte) begin
                data_reg <= asm_next;
            end
            if (state_reg == ST_WRITE) begin
                addr_reg      <= addr_reg + 32'd4;
                remaining_reg <= remaining_reg - CNT_WIDTH'(1);
            end
        end
    end

    assign memAddr = addr_reg;
    assign memData = data_reg;
    assign error   = error_reg;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader: a word-level scoreboard predicts every
// memory write, the done/error pulse timing and the final address.
module tb_rom_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 128;
    localparam int          CW    = 16;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] wordCount = '0;
    logic [7:0]    byteIn = 8'h00;
    logic          byteValid = 1'b0;
    logic          byteReady;
    logic          memWr;
    logic [31:0]   memAddr;
    logic [31:0]   memData;
    logic          busy;
    logic          done;
    logic          error;

    rom_loader #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .start    (start),
        .wordCount(wordCount),
        .byteIn   (byteIn),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .memData  (memData),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          ready_cycles = 0;
    wr_t         wr_q[$];
    int          done_q[$];
    int          err_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  bytes_q[$];
    int          byte_ptr = 0;

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge CLK) begin
        wr_t w;
        cyc = cyc + 1;
        #1;
        if (memWr) begin
            w.addr = memAddr;
            w.data = memData;
            w.cyc  = cyc;
            wr_q.push_back(w);
            $display("write cyc=%0d addr=%08h data=%08h", cyc, memAddr, memData);
        end
        if (done)      done_q.push_back(cyc);
        if (error)     err_q.push_back(cyc);
        if (byteReady) ready_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        done_q.delete();
        err_q.delete();
        ready_cycles = 0;
    endtask

    task automatic fill_words(input int n);
        words_q.delete();
        repeat (n) words_q.push_back($urandom);
    endtask

    // Big-endian split: the most significant byte of each word goes first.
    task automatic build_bytes();
        bytes_q.delete();
        foreach (words_q[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] sh;
                sh = words_q[i] >> (24 - 8*k);
                bytes_q.push_back(sh[7:0]);
            end
        end
        byte_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0;
        start = 1'b0;
        byteValid = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    // A junk byte is offered alongside start; it must not be taken in IDLE.
    task automatic pulse_start(input int cnt, output int sc);
        @(negedge CLK);
        start     = 1'b1;
        wordCount = CW'(cnt);
        byteValid = 1'b1;
        byteIn    = 8'hEE;
        sc        = cyc;
        @(negedge CLK);
        start     = 1'b0;
        byteValid = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int gap);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 4000) begin
            byteValid = 1'b1;
            byteIn    = bytes_q[byte_ptr];
            if (byteReady) begin
                byte_ptr++;
                sent++;
                @(negedge CLK);
                byteValid = 1'b0;
                repeat (gap) @(negedge CLK);
            end else begin
                @(negedge CLK);
            end
            guard++;
        end
        byteValid = 1'b0;
        if (sent < n) check("send_timeout", sent, n);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_q.size() == 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (done_q.size() == 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_load(input int sc, input int timed);
        check("wr_count", wr_q.size(), words_q.size());
        foreach (words_q[i]) begin
            if (i < wr_q.size()) begin
                check("wr_addr", wr_q[i].addr, BASE + 32'(4*i));
                check("wr_data", wr_q[i].data, words_q[i]);
                if (timed != 0) check("wr_cyc", wr_q[i].cyc, sc + 5*(i+1));
            end
        end
        check("done_count", done_q.size(), 1);
        if (done_q.size() > 0 && wr_q.size() > 0) check("done_lat", done_q[0], wr_q[$].cyc + 1);
        check("err_count", err_q.size(), 0);
        check("busy_after", busy, 0);
        check("addr_after", memAddr, BASE + 32'(4*words_q.size()));
    endtask

    task automatic run_words(input int gap, input int timed);
        int sc;
        build_bytes();
        clear_mon();
        pulse_start(words_q.size(), sc);
        send_bytes(words_q.size()*4, gap);
        wait_done(50);
        repeat (2) @(negedge CLK);
        check_load(sc, timed);
    endtask

    initial begin
        int sc;
        repeat (3) @(negedge CLK);
        check("rst_byteReady", byteReady, 0);
        check("rst_memWr", memWr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_memAddr", memAddr, BASE);
        check("rst_memData", memData, 0);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic load, continuous bytes
        words_q.delete();
        words_q.push_back(32'h2001_0008);
        words_q.push_back(32'hAC02_0004);
        run_words(0, 1);

        // Same words with 3-cycle gaps between bytes
        run_words(3, 0);

        // Zero count
        clear_mon();
        pulse_start(0, sc);
        repeat (4) @(negedge CLK);
        check("zero_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("zero_done_cyc", done_q[0], sc + 1);
        check("zero_wr_count", wr_q.size(), 0);
        check("zero_ready", ready_cycles, 0);
        check("zero_busy", busy, 0);

        // Overflow rejected, then a normal 1-word load
        clear_mon();
        pulse_start(DEPTH + 1, sc);
        repeat (4) @(negedge CLK);
        check("ovf_err_count", err_q.size(), 1);
        if (err_q.size() > 0) check("ovf_err_cyc", err_q[0], sc + 1);
        check("ovf_wr_count", wr_q.size(), 0);
        check("ovf_done_count", done_q.size(), 0);
        check("ovf_ready", ready_cycles, 0);
        fill_words(1);
        run_words(0, 1);

        // Reset after two bytes of the first word
        fill_words(2);
        build_bytes();
        clear_mon();
        pulse_start(2, sc);
        send_bytes(2, 0);
        do_reset();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", byteReady, 0);
        check("mid_rst_addr", memAddr, BASE);
        check("mid_rst_data", memData, 0);
        check("mid_rst_wr", wr_q.size(), 0);
        words_q.delete();
        words_q.push_back(32'h1122_3344);
        run_words(0, 1);

        // Start pulsed during COLLECT is ignored
        fill_words(3);
        build_bytes();
        clear_mon();
        pulse_start(3, sc);
        send_bytes(2, 0);
        start     = 1'b1;
        wordCount = CW'(1);
        @(negedge CLK);
        start = 1'b0;
        send_bytes(10, 1);
        wait_done(50);
        repeat (2) @(negedge CLK);
        check_load(sc, 0);

        // Random loads
        for (int t = 0; t < 6; t++) begin
            int g;
            g = $urandom_range(0, 2);
            fill_words($urandom_range(1, 6));
            run_words(g, (g == 0) ? 1 : 0);
        end

        // Full-depth load
        fill_words(DEPTH);
        run_words(0, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
